// File: rtl/period_tracker.sv
// Period tracker: locks onto a pulse stream arriving every PERIOD +/- TOLERANCE
// cycles, flywheels through missing events and tags each forwarded word.
module period_tracker #(
    parameter int DATA_WIDTH = 48,
    parameter int PERIOD     = 100,
    parameter int TOLERANCE  = 4,
    parameter int LOCK_COUNT = 3,
    parameter int MISS_LIMIT = 2,
    localparam int PW        = $clog2(PERIOD + TOLERANCE + 2)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_in_window,
    output logic [PW-1:0]         out_phase,
    output logic                  locked,
    output logic                  sync_pulse,
    output logic                  missed
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    localparam logic [PW-1:0] SAT      = PW'(PERIOD + TOLERANCE + 1);
    localparam logic [PW-1:0] LATE     = PW'(PERIOD + TOLERANCE);
    localparam logic [PW-1:0] EARLY    = PW'(PERIOD - TOLERANCE);
    localparam logic [PW-1:0] REANCHOR = PW'(TOLERANCE + 1);
    localparam logic [PW-1:0] ANCHOR   = PW'(1);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   elapsed, elapsed_n;
    logic [GW-1:0]   good, good_n;
    logic [MW-1:0]   misses, misses_n;
    logic            sync_n, missed_n, in_win;

    assign in_win = (elapsed >= EARLY) && (elapsed <= LATE);

    always_comb begin
        state_n   = state;
        good_n    = good;
        misses_n  = misses;
        sync_n    = 1'b0;
        missed_n  = 1'b0;
        elapsed_n = (elapsed == SAT) ? SAT : elapsed + PW'(1);
        case (state)
            SEARCH: begin
                if (in_valid) begin
                    elapsed_n = ANCHOR;
                    good_n    = GW'(1);
                    state_n   = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (in_valid) begin
                    elapsed_n = ANCHOR;
                    if (in_win) begin
                        good_n = good + GW'(1);
                        if (good + GW'(1) == GW'(LOCK_COUNT)) begin
                            state_n  = LOCKED;
                            misses_n = '0;
                            sync_n   = 1'b1;
                        end
                    end else begin
                        good_n = GW'(1);
                    end
                end else if (elapsed == LATE) begin
                    state_n = SEARCH;
                    good_n  = '0;
                end
            end
            LOCKED: begin
                // Early events are glitches: forwarded but never re-anchor timing.
                if (in_valid && in_win) begin
                    elapsed_n = ANCHOR;
                    misses_n  = '0;
                    sync_n    = 1'b1;
                end else if (!in_valid && elapsed == LATE) begin
                    elapsed_n = REANCHOR;
                    sync_n    = 1'b1;
                    missed_n  = 1'b1;
                    misses_n  = misses + MW'(1);
                    if (misses + MW'(1) == MW'(MISS_LIMIT)) begin
                        state_n = SEARCH;
                        good_n  = '0;
                    end
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SEARCH;
            elapsed       <= SAT;
            good          <= '0;
            misses        <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_in_window <= 1'b0;
            out_phase     <= '0;
            locked        <= 1'b0;
            sync_pulse    <= 1'b0;
            missed        <= 1'b0;
        end else begin
            state         <= state_n;
            elapsed       <= elapsed_n;
            good          <= good_n;
            misses        <= misses_n;
            out_valid     <= in_valid;
            out_data      <= in_data;
            out_in_window <= in_valid && in_win && (state != SEARCH);
            out_phase     <= elapsed;
            locked        <= (state_n == LOCKED);
            sync_pulse    <= sync_n;
            missed        <= missed_n;
        end
    end
endmodule
